fb_arbiter: RTL and testbench

//  Shares one single-port 12-bit pixel RAM between vgac scanout (reads) and game/sprite logic (writes).
//  The RAM is double-buffered: vgac displays the front buffer while writers fill the back buffer.

---
 rtl/fb_arbiter.sv | 118 +++++++++++
 tb/tb_fb_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer RAM arbiter -- scanout reads win, queued writes fill the back buffer,
// buffer swap deferred to vertical blanking once the write queue has drained.  Rev 1.0
`default_nettype none

module fb_arbiter #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic        vga_clk,
   input  logic        clrn,
   input  logic        rdn,
   input  logic [8:0]  row_addr,
   input  logic [9:0]  col_addr,
   input  logic        vs,
   output logic [11:0] d_in,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [8:0]  wr_row,
   input  logic [9:0]  wr_col,
   input  logic [11:0] wr_data,
   input  logic        swap_req,
   output logic        swap_busy,
   output logic        swap_done,
   output logic        front_sel,
   output logic [19:0] ram_addr,
   output logic        ram_we,
   output logic [11:0] ram_wdata,
   input  logic [11:0] ram_rdata
);

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } state_t;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   state_t        state_q, state_d;
   logic          front_q, front_d;
   logic          vs_q;
   logic [AW-1:0] wp_q, rp_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic [30:0]   mem_q [DEPTH];

   logic          w_empty, w_full, w_push, w_pop, w_in_range, w_vs_fall;
   logic [30:0]   w_head;

   assign w_empty    = (cnt_q == '0);
   assign w_full     = (cnt_q == FULL_CNT);
   assign w_vs_fall  = vs_q & ~vs;
   assign w_in_range = (wr_row < 9'd480) && (wr_col < 10'd640);
   assign w_head     = mem_q[rp_q];

   assign swap_busy  = (state_q == PEND);
   assign wr_ready   = ~w_full & ~swap_busy;
   // Out-of-range writes still handshake but never reach the queue.
   assign w_push     = wr_valid & wr_ready & w_in_range;
   assign w_pop      = rdn & ~w_empty;

   assign front_sel  = front_q;
   assign d_in       = ram_rdata;
   assign ram_we     = w_pop;
   assign ram_wdata  = w_head[11:0];
   assign ram_addr   = w_pop ? {~front_q, w_head[30:12]} : {front_q, row_addr, col_addr};

   always_comb begin
      cnt_d = cnt_q;
      case ({w_push, w_pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      front_d   = front_q;
      swap_done = 1'b0;
      case (state_q)
         RUN: begin
            if (swap_req) state_d = PEND;
         end
         PEND: begin
            if (w_vs_fall && w_empty) begin
               front_d   = ~front_q;
               swap_done = 1'b1;
               state_d   = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         state_q <= RUN;
         front_q <= 1'b0;
         vs_q    <= 1'b1;
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         front_q <= front_d;
         vs_q    <= vs;
         cnt_q   <= cnt_d;
         if (w_push) wp_q <= wp_q + AW'(1);
         if (w_pop)  rp_q <= rp_q + AW'(1);
      end
   end

   always_ff @(posedge vga_clk) begin
      if (w_push) mem_q[wp_q] <= {wr_row, wr_col, wr_data};
   end

endmodule

`default_nettype wire

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: scoreboard bench for fb_arbiter; expected RAM writes are queued at accept time.
`default_nettype none

module tb_fb_arbiter;

   logic        vga_clk = 1'b0;
   logic        clrn = 1'b0, rdn = 1'b0, vs = 1'b1, wr_valid = 1'b0, swap_req = 1'b0;
   logic [8:0]  row_addr = 9'd0, wr_row = 9'd0;
   logic [9:0]  col_addr = 10'd0, wr_col = 10'd0;
   logic [11:0] wr_data = 12'd0, ram_rdata = 12'hABC;
   logic [11:0] d_in, ram_wdata;
   logic        wr_ready, swap_busy, swap_done, front_sel, ram_we;
   logic [19:0] ram_addr;

   int          total = 0, bad = 0, we_seen = 0, base;
   logic        exp_front = 1'b0;
   logic [31:0] sb[$];
   logic [31:0] e;

   fb_arbiter #(.DEPTH(16), .AW(4)) dut (
      .vga_clk(vga_clk), .clrn(clrn), .rdn(rdn), .row_addr(row_addr), .col_addr(col_addr),
      .vs(vs), .d_in(d_in), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row),
      .wr_col(wr_col), .wr_data(wr_data), .swap_req(swap_req), .swap_busy(swap_busy),
      .swap_done(swap_done), .front_sel(front_sel), .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge vga_clk);
      #1;
   endtask

   // A RAM write is due exactly when scanout is idle and the modelled queue holds something.
   always @(negedge vga_clk) begin
      if (clrn) begin
         check_eq("we_expect", {31'd0, ram_we}, {31'd0, rdn && (sb.size() != 0)});
         if (ram_we && sb.size() != 0) begin
            we_seen++;
            e = sb.pop_front();
            check_eq("wr_addr", {12'd0, ram_addr}, {12'd0, e[31:12]});
            check_eq("wr_data", {20'd0, ram_wdata}, {20'd0, e[11:0]});
         end
      end
   end

   task automatic push_wr(input logic [8:0] r, input logic [9:0] c, input logic [11:0] d);
      int n = 0;
      wr_valid = 1'b1; wr_row = r; wr_col = c; wr_data = d;
      #1;
      while (!wr_ready && n < 50) begin
         step();
         n++;
      end
      check_eq("wr_accept", {31'd0, wr_ready}, 32'd1);
      step();
      wr_valid = 1'b0;
      if (r < 9'd480 && c < 10'd640) sb.push_back({~exp_front, r, c, d});
   endtask

   task automatic drain();
      int n = 0;
      rdn = 1'b1;
      while (sb.size() != 0 && n < 100) begin
         step();
         n++;
      end
      check_eq("drain_bound", {31'd0, sb.size() == 0}, 32'd1);
   endtask

   task automatic swap_empty();
      swap_req = 1'b1; step(); swap_req = 1'b0;
      step();
      vs = 1'b0; #1;
      check_eq("swap_done_pulse", {31'd0, swap_done}, 32'd1);
      step();
      exp_front = ~exp_front;
      check_eq("front_after_swap", {31'd0, front_sel}, {31'd0, exp_front});
      check_eq("busy_after_swap", {31'd0, swap_busy}, 32'd0);
      check_eq("done_one_cycle", {31'd0, swap_done}, 32'd0);
      step(); vs = 1'b1; step(); step();
   endtask

   initial begin
      // 1: reset state and zero-latency read path
      rdn = 1'b0; row_addr = 9'd5; col_addr = 10'd7;
      #1;
      check_eq("rst_addr", {12'd0, ram_addr}, 32'h01407);
      check_eq("rst_we", {31'd0, ram_we}, 32'd0);
      check_eq("rst_front", {31'd0, front_sel}, 32'd0);
      check_eq("rst_busy", {31'd0, swap_busy}, 32'd0);
      check_eq("rst_done", {31'd0, swap_done}, 32'd0);
      check_eq("rst_ready", {31'd0, wr_ready}, 32'd1);
      check_eq("rst_din", {20'd0, d_in}, 32'hABC);
      step(); step(); clrn = 1'b1; step();
      ram_rdata = 12'h5A3; #1;
      check_eq("din_comb", {20'd0, d_in}, 32'h5A3);

      // 2: writes wait behind scanout, then issue back to back in order
      push_wr(9'd1, 10'd2, 12'hF00);
      push_wr(9'd3, 10'd4, 12'h0F0);
      push_wr(9'd479, 10'd639, 12'h00F);
      step();
      check_eq("read_prio_addr", {12'd0, ram_addr}, 32'h01407);
      base = we_seen;
      drain();
      step();
      check_eq("burst_len", we_seen - base, 32'd3);
      check_eq("idle_addr", {12'd0, ram_addr}, 32'h01407);

      // 3: fill to DEPTH, a single pop frees one slot
      rdn = 1'b0;
      for (int i = 0; i < 16; i++) push_wr(9'(10 + i), 10'(i * 3), 12'(i * 17 + 1));
      #1;
      check_eq("full_ready", {31'd0, wr_ready}, 32'd0);
      rdn = 1'b1; step(); rdn = 1'b0;
      check_eq("pop_ready", {31'd0, wr_ready}, 32'd1);
      drain();
      rdn = 1'b0;

      // 4: swap with an empty queue
      swap_empty();

      // 5: swap blocked by pending writes, applied one frame later
      for (int i = 0; i < 4; i++) push_wr(9'(100 + i), 10'(200 + i), 12'(12'h321 + i));
      swap_req = 1'b1; step(); swap_req = 1'b0;
      check_eq("pend_busy", {31'd0, swap_busy}, 32'd1);
      check_eq("pend_ready", {31'd0, wr_ready}, 32'd0);
      vs = 1'b0; #1;
      check_eq("pend_no_done", {31'd0, swap_done}, 32'd0);
      step();
      check_eq("pend_front_kept", {31'd0, front_sel}, {31'd0, exp_front});
      check_eq("pend_still_busy", {31'd0, swap_busy}, 32'd1);
      step(); vs = 1'b1; step(); step();
      drain();
      step();
      vs = 1'b0; #1;
      check_eq("retry_done", {31'd0, swap_done}, 32'd1);
      step();
      exp_front = ~exp_front;
      check_eq("retry_front", {31'd0, front_sel}, {31'd0, exp_front});
      check_eq("retry_busy", {31'd0, swap_busy}, 32'd0);
      step(); vs = 1'b1; step(); step();

      // 6: out-of-range writes vanish; reset drops queue and pending swap
      rdn = 1'b1;
      push_wr(9'd480, 10'd5, 12'hBAD);
      push_wr(9'd7, 10'd640, 12'hBAD);
      repeat (4) step();
      rdn = 1'b0;
      swap_empty();
      for (int i = 0; i < 5; i++) push_wr(9'(300 + i), 10'(i), 12'(12'hA00 + i));
      swap_req = 1'b1; step(); swap_req = 1'b0;
      check_eq("pre_rst_busy", {31'd0, swap_busy}, 32'd1);
      clrn = 1'b0; sb.delete(); exp_front = 1'b0; rdn = 1'b1;
      #1;
      check_eq("mid_rst_front", {31'd0, front_sel}, 32'd0);
      check_eq("mid_rst_busy", {31'd0, swap_busy}, 32'd0);
      check_eq("mid_rst_we", {31'd0, ram_we}, 32'd0);
      check_eq("mid_rst_ready", {31'd0, wr_ready}, 32'd1);
      step(); clrn = 1'b1;
      repeat (6) step();
      check_eq("post_rst_addr", {12'd0, ram_addr}, 32'h01407);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
